player_bullet_spawner: RTL and testbench

- Owns the player-bullet slot table and is the producer of the player-bullet state and position vectors that collision detection consumes.
- Accepts fire requests from the input controller and allocates free slots, and advances bullets upward once per frame.
- Retires bullets at the top border and applies kill masks from collision detection.
- Sits between the input/player logic and the collision/render stages in the game frame loop.

---
 rtl/player_bullet_spawner_pkg.sv | 32 +++
 rtl/player_bullet_spawner_lowest_free_slot.sv | 24 ++
 rtl/player_bullet_spawner.sv | 107 ++++++++++
 tb/tb_player_bullet_spawner.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/player_bullet_spawner_pkg.sv
// Shared constants and position helpers for the player-bullet slot table.
// Positions pack {x[9:0], y[8:0]}; the all-ones code marks an empty slot.
package player_bullet_spawner_pkg;

    localparam logic [8:0]  MONITOR_HEIGHT        = 9'd480;
    localparam int unsigned MAX_PLAYER_BULLET     = 15;
    localparam logic [9:0]  BULLET_WIDTH          = 10'd4;
    localparam logic [8:0]  BULLET_HEIGHT         = 9'd16;
    localparam logic [9:0]  PLAYER_WIDTH          = 10'd24;
    localparam logic [8:0]  PLAYER_Y              = 9'd440;
    localparam logic [8:0]  BULLET_SPEED          = 9'd4;
    localparam logic [3:0]  FIRE_COOLDOWN_DEFAULT = 4'd8;
    localparam int unsigned POS_W                 = 19;
    localparam logic [18:0] NONE                  = {19{1'b1}};

    localparam int unsigned POS_X_HI = 18;
    localparam int unsigned POS_X_LO = 9;
    localparam int unsigned POS_Y_HI = 8;
    localparam int unsigned POS_Y_LO = 0;

    localparam logic [9:0] SPAWN_X_OFFSET = (PLAYER_WIDTH - BULLET_WIDTH) >> 1;
    localparam logic [8:0] SPAWN_Y        = PLAYER_Y - BULLET_HEIGHT;

    function automatic logic [8:0] pos_y(input logic [18:0] pos);
        return pos[POS_Y_HI:POS_Y_LO];
    endfunction

    function automatic logic [18:0] make_pos(input logic [9:0] x, input logic [8:0] y);
        return {x, y};
    endfunction

endpackage

// File: rtl/player_bullet_spawner_lowest_free_slot.sv
// Combinational priority encoder: index of the lowest clear bit of a slot-state vector.
module lowest_free_slot #(
    parameter int unsigned N = 15
) (
    input  logic [N-1:0]         state,
    output logic                 found,
    output logic [$clog2(N)-1:0] index
);

    localparam int unsigned IDX_W = $clog2(N);

    always_comb begin
        found = 1'b0;
        index = '0;
        // Scan high to low so the lowest free index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (!state[i]) begin
                found = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/player_bullet_spawner.sv
// Player-bullet slot table: spawns on fire, moves bullets up each frame,
// retires them at the top border and applies collision kill masks.
module player_bullet_spawner
    import player_bullet_spawner_pkg::*;
#(
    parameter logic [3:0] FIRE_COOLDOWN = FIRE_COOLDOWN_DEFAULT
) (
    input  logic                                 i_Clk,
    input  logic                                 i_Reset,
    input  logic                                 i_FrameTick,
    input  logic                                 i_Fire,
    input  logic                                 i_PlayerState,
    input  logic [9:0]                           i_PlayerPosition,
    input  logic [MAX_PLAYER_BULLET-1:0]         i_BulletKill,
    output logic [MAX_PLAYER_BULLET-1:0]         o_PlayerBulletState,
    output logic [POS_W*MAX_PLAYER_BULLET-1:0]   o_PlayerBulletPosition,
    output logic                                 o_FireAccepted,
    output logic [$clog2(MAX_PLAYER_BULLET+1)-1:0] o_ActiveCount
);

    localparam int unsigned N     = MAX_PLAYER_BULLET;
    localparam int unsigned IDX_W = $clog2(N);
    localparam int unsigned CNT_W = $clog2(N + 1);

    // The spawn tick itself counts as one tick of spacing, so shots land
    // exactly FIRE_COOLDOWN ticks apart.
    localparam logic [3:0] COOLDOWN_LOAD = (FIRE_COOLDOWN == 4'd0) ? 4'd0 : FIRE_COOLDOWN - 4'd1;

    logic [N-1:0]            state_q, state_d;
    logic [N-1:0][POS_W-1:0] pos_q, pos_d;
    logic [3:0]              cooldown_q, cooldown_d;
    logic                    fire_acc_q, fire_acc_d;
    logic [CNT_W-1:0]        count_q, count_d;

    logic             free_found;
    logic [IDX_W-1:0] free_index;
    logic             spawn;

    lowest_free_slot #(
        .N(N)
    ) u_lowest_free_slot (
        .state(state_q),
        .found(free_found),
        .index(free_index)
    );

    assign spawn = i_FrameTick && i_Fire && i_PlayerState && (cooldown_q == 4'd0) && free_found;

    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        cooldown_d = cooldown_q;
        fire_acc_d = spawn;
        count_d    = '0;

        for (int k = 0; k < N; k++) begin
            if (state_q[k]) begin
                if (i_BulletKill[k]) begin
                    state_d[k] = 1'b0;
                    pos_d[k]   = NONE;
                end else if (i_FrameTick) begin
                    if (pos_y(pos_q[k]) < BULLET_SPEED) begin
                        state_d[k] = 1'b0;
                        pos_d[k]   = NONE;
                    end else begin
                        pos_d[k][POS_Y_HI:POS_Y_LO] = pos_y(pos_q[k]) - BULLET_SPEED;
                    end
                end
            end
        end

        // The chosen slot was empty before this cycle, so any kill on it is stale.
        if (spawn) begin
            state_d[free_index] = 1'b1;
            pos_d[free_index]   = make_pos(i_PlayerPosition + SPAWN_X_OFFSET, SPAWN_Y);
            cooldown_d          = COOLDOWN_LOAD;
        end else if (i_FrameTick && cooldown_q != 4'd0) begin
            cooldown_d = cooldown_q - 4'd1;
        end

        for (int k = 0; k < N; k++) begin
            count_d = count_d + CNT_W'(state_d[k]);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q    <= '0;
            pos_q      <= {N{NONE}};
            cooldown_q <= 4'd0;
            fire_acc_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            cooldown_q <= cooldown_d;
            fire_acc_q <= fire_acc_d;
            count_q    <= count_d;
        end
    end

    assign o_PlayerBulletState    = state_q;
    assign o_PlayerBulletPosition = pos_q;
    assign o_FireAccepted         = fire_acc_q;
    assign o_ActiveCount          = count_q;

endmodule

// File: tb/tb_player_bullet_spawner.sv
// Directed bench for player_bullet_spawner: default build plus a zero-cooldown build.
module tb_player_bullet_spawner;

    localparam int N = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          frame_tick = 1'b0;
    logic          fire = 1'b0;
    logic          player_state = 1'b1;
    logic [9:0]    player_x = 10'd100;
    logic [N-1:0]  kill = '0;

    logic [N-1:0]    st_a, st_b;
    logic [19*N-1:0] pos_a, pos_b;
    logic            acc_a, acc_b;
    logic [3:0]      cnt_a, cnt_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    player_bullet_spawner u_dut (
        .i_Clk(clk), .i_Reset(reset), .i_FrameTick(frame_tick), .i_Fire(fire),
        .i_PlayerState(player_state), .i_PlayerPosition(player_x), .i_BulletKill(kill),
        .o_PlayerBulletState(st_a), .o_PlayerBulletPosition(pos_a),
        .o_FireAccepted(acc_a), .o_ActiveCount(cnt_a)
    );

    player_bullet_spawner #(.FIRE_COOLDOWN(4'd0)) u_dut_nocd (
        .i_Clk(clk), .i_Reset(reset), .i_FrameTick(frame_tick), .i_Fire(fire),
        .i_PlayerState(player_state), .i_PlayerPosition(player_x), .i_BulletKill(kill),
        .o_PlayerBulletState(st_b), .o_PlayerBulletPosition(pos_b),
        .o_FireAccepted(acc_b), .o_ActiveCount(cnt_b)
    );

    function automatic logic [18:0] slot_a(input int k);
        return pos_a[19*k +: 19];
    endfunction

    function automatic logic [18:0] slot_b(input int k);
        return pos_b[19*k +: 19];
    endfunction

    // Inputs change on the falling edge; outputs are sampled on the next falling edge.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; frame_tick = 1'b0; fire = 1'b0; kill = '0;
        player_state = 1'b1; player_x = 10'd100;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic tick(input logic f, input logic [N-1:0] k);
        frame_tick = 1'b1; fire = f; kill = k;
        @(negedge clk);
        frame_tick = 1'b0; fire = 1'b0; kill = '0;
    endtask

    task automatic idle(input logic [N-1:0] k);
        kill = k;
        @(negedge clk);
        kill = '0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (st_a !== '0 || cnt_a !== 4'd0 || acc_a !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: st=%h cnt=%0d acc=%b, want 0/0/0", st_a, cnt_a, acc_a);
        end
        tests++;
        if (pos_a !== {(19*N){1'b1}}) begin
            fails++;
            $display("FAIL reset_pos: got %h, want all NONE", pos_a);
        end
    endtask

    task automatic test_single_fire();
        do_reset();
        tick(1'b1, '0);
        tests++;
        if (st_a !== 15'h0001 || slot_a(0) !== {10'd110, 9'd424} || acc_a !== 1'b1 || cnt_a !== 4'd1) begin
            fails++;
            $display("FAIL single_fire: st=%h pos0=%h acc=%b cnt=%0d, want 0001/%h/1/1",
                     st_a, slot_a(0), acc_a, cnt_a, {10'd110, 9'd424});
        end
        idle('0);
        tests++;
        if (acc_a !== 1'b0) begin
            fails++;
            $display("FAIL single_pulse: acc=%b, want 0", acc_a);
        end
    endtask

    task automatic test_hold_fire();
        logic [20:1] hits;
        hits = '0;
        do_reset();
        for (int t = 1; t <= 20; t++) begin
            tick(1'b1, '0);
            hits[t] = acc_a;
            if (t == 17) begin
                tests++;
                if (slot_a(0) !== {10'd110, 9'd360}) begin
                    fails++;
                    $display("FAIL hold_slot0_y: got %h, want %h", slot_a(0), {10'd110, 9'd360});
                end
            end
        end
        tests++;
        if (hits !== 20'b0000_1000_0000_1000_0000 >> 0 && hits !== ((20'd1 << 0) | (20'd1 << 8) | (20'd1 << 16))) begin
            fails++;
            $display("FAIL hold_spawn_ticks: got %b, want ticks 1,9,17", hits);
        end
        tests++;
        if (st_a !== 15'h0007 || cnt_a !== 4'd3) begin
            fails++;
            $display("FAIL hold_slots: st=%h cnt=%0d, want 0007/3", st_a, cnt_a);
        end
    endtask

    task automatic test_retire();
        do_reset();
        tick(1'b1, '0);
        for (int t = 1; t <= 106; t++) tick(1'b0, '0);
        tests++;
        if (st_a !== 15'h0001 || slot_a(0) !== {10'd110, 9'd0}) begin
            fails++;
            $display("FAIL retire_at_top: st=%h pos0=%h, want 0001/%h", st_a, slot_a(0), {10'd110, 9'd0});
        end
        tick(1'b0, '0);
        tests++;
        if (st_a !== '0 || slot_a(0) !== 19'h7FFFF || cnt_a !== 4'd0) begin
            fails++;
            $display("FAIL retire_gone: st=%h pos0=%h cnt=%0d, want 0/7ffff/0", st_a, slot_a(0), cnt_a);
        end
    endtask

    task automatic test_kill();
        logic [18:0] p0, p2;
        int waited;
        do_reset();
        for (int t = 1; t <= 17; t++) tick(1'b1, '0);
        p0 = slot_a(0);
        p2 = slot_a(2);
        idle(15'h0002);
        tests++;
        if (st_a !== 15'h0005 || slot_a(1) !== 19'h7FFFF || slot_a(0) !== p0 || slot_a(2) !== p2
            || cnt_a !== 4'd2) begin
            fails++;
            $display("FAIL kill_mid_frame: st=%h pos1=%h cnt=%0d, want 0005/7ffff/2", st_a, slot_a(1), cnt_a);
        end
        idle(15'h0020);
        tests++;
        if (st_a !== 15'h0005 || slot_a(5) !== 19'h7FFFF) begin
            fails++;
            $display("FAIL kill_inactive: st=%h pos5=%h, want 0005/7ffff", st_a, slot_a(5));
        end
        // Cooldown was loaded on tick 17; the next shot lands 8 ticks later.
        waited = 0;
        tick(1'b1, '0);
        while (acc_a !== 1'b1 && waited < 12) begin
            tick(1'b1, '0);
            waited++;
        end
        tests++;
        if (acc_a !== 1'b1 || waited != 7 || st_a !== 15'h0007 || slot_a(1) !== {10'd110, 9'd424}) begin
            fails++;
            $display("FAIL kill_reuse: acc=%b waited=%0d st=%h pos1=%h, want 1/7/0007/%h",
                     acc_a, waited, st_a, slot_a(1), {10'd110, 9'd424});
        end
        // Kill and movement on the same tick: kill wins.
        tick(1'b0, 15'h0001);
        tests++;
        if (st_a !== 15'h0006 || slot_a(0) !== 19'h7FFFF || slot_a(1) !== {10'd110, 9'd420}) begin
            fails++;
            $display("FAIL kill_vs_move: st=%h pos0=%h pos1=%h, want 0006/7ffff/%h",
                     st_a, slot_a(0), slot_a(1), {10'd110, 9'd420});
        end
    endtask

    task automatic test_full_table();
        do_reset();
        for (int t = 1; t <= 15; t++) tick(1'b1, '0);
        tests++;
        if (st_b !== 15'h7FFF || cnt_b !== 4'd15) begin
            fails++;
            $display("FAIL full_fill: st=%h cnt=%0d, want 7fff/15", st_b, cnt_b);
        end
        tick(1'b1, '0);
        tests++;
        if (acc_b !== 1'b0 || st_b !== 15'h7FFF) begin
            fails++;
            $display("FAIL full_drop: acc=%b st=%h, want 0/7fff", acc_b, st_b);
        end
        idle(15'h0080);
        tests++;
        if (st_b !== 15'h7F7F || slot_b(7) !== 19'h7FFFF || cnt_b !== 4'd14) begin
            fails++;
            $display("FAIL full_kill7: st=%h pos7=%h cnt=%0d, want 7f7f/7ffff/14", st_b, slot_b(7), cnt_b);
        end
        // Stale kill on the slot being spawned into must not cancel the spawn.
        tick(1'b1, 15'h0080);
        tests++;
        if (acc_b !== 1'b1 || st_b !== 15'h7FFF || slot_b(7) !== {10'd110, 9'd424}) begin
            fails++;
            $display("FAIL full_respawn7: acc=%b st=%h pos7=%h, want 1/7fff/%h",
                     acc_b, st_b, slot_b(7), {10'd110, 9'd424});
        end
    endtask

    task automatic test_player_dead_and_reset();
        logic any_acc;
        any_acc = 1'b0;
        do_reset();
        tick(1'b1, '0);
        player_state = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            tick(1'b1, '0);
            any_acc = any_acc | acc_a;
        end
        tests++;
        if (any_acc !== 1'b0 || st_a !== 15'h0001 || slot_a(0) !== {10'd110, 9'd384}) begin
            fails++;
            $display("FAIL dead_no_spawn: acc_seen=%b st=%h pos0=%h, want 0/0001/%h",
                     any_acc, st_a, slot_a(0), {10'd110, 9'd384});
        end
        player_state = 1'b1;
        reset = 1'b1; frame_tick = 1'b1; fire = 1'b1;
        @(negedge clk);
        tests++;
        if (st_a !== '0 || pos_a !== {(19*N){1'b1}} || acc_a !== 1'b0 || cnt_a !== 4'd0) begin
            fails++;
            $display("FAIL reset_priority: st=%h acc=%b cnt=%0d, want 0/0/0", st_a, acc_a, cnt_a);
        end
        reset = 1'b0; frame_tick = 1'b0; fire = 1'b0;
        // Cooldown must also have been cleared: immediate fire succeeds.
        tick(1'b1, '0);
        tests++;
        if (acc_a !== 1'b1 || st_a !== 15'h0001) begin
            fails++;
            $display("FAIL reset_cooldown: acc=%b st=%h, want 1/0001", acc_a, st_a);
        end
    endtask

    initial begin
        test_reset();
        test_single_fire();
        test_hold_fire();
        test_retire();
        test_kill();
        test_full_table();
        test_player_dead_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
